// File: rtl/branch_sched_pkg.sv
// Shared definitions for the ID-stage branch sequencer: comparator opcodes,
// FSM state encoding and the default datapath width.
package branch_sched_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [3:0] CMP_EQ = 4'd0;
  localparam logic [3:0] CMP_GE = 4'd1;
  localparam logic [3:0] CMP_GT = 4'd2;
  localparam logic [3:0] CMP_LE = 4'd3;
  localparam logic [3:0] CMP_LT = 4'd4;
  localparam logic [3:0] CMP_NE = 4'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    EVAL = 2'd2
  } state_t;

endpackage

// File: rtl/branch_sched_if.sv
// ID-stage <-> branch sequencer bundle: branch request and forwarding status in,
// stall/redirect/resolve status and statistics out.
interface branch_sched_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int CNT_W  = 16
);

  logic              br_valid;
  logic [OP_W-1:0]   br_op;
  logic              rs_ready;
  logic              rt_ready;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [DATA_W-1:0] br_target;
  logic              flush;

  logic              stall;
  logic              npc_sel;
  logic [DATA_W-1:0] npc_target;
  logic              br_done;
  logic              br_taken;
  logic              bad_op;
  logic              hang_err;
  logic [CNT_W-1:0]  taken_cnt;
  logic [CNT_W-1:0]  nt_cnt;

  modport master (
    output br_valid, br_op, rs_ready, rt_ready, rs_data, rt_data, br_target, flush,
    input  stall, npc_sel, npc_target, br_done, br_taken, bad_op, hang_err,
           taken_cnt, nt_cnt
  );

  modport slave (
    input  br_valid, br_op, rs_ready, rt_ready, rs_data, rt_data, br_target, flush,
    output stall, npc_sel, npc_target, br_done, br_taken, bad_op, hang_err,
           taken_cnt, nt_cnt
  );

endinterface

// File: rtl/branch_sched_comparator.sv
// Unsigned branch comparator: branch=1 when A1 <OP> A2 holds; unknown ops never branch.
module branch_sched_comparator
  import branch_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OP_W   = 4
) (
  input  logic [DATA_W-1:0] A1,
  input  logic [DATA_W-1:0] A2,
  input  logic [OP_W-1:0]   OP,
  output logic              branch
);

  // Opcode decode and compare
  always_comb begin
    branch = 1'b0;
    case (OP)
      OP_W'(CMP_EQ): branch = (A1 == A2);
      OP_W'(CMP_GE): branch = (A1 >= A2);
      OP_W'(CMP_GT): branch = (A1 >  A2);
      OP_W'(CMP_LE): branch = (A1 <= A2);
      OP_W'(CMP_LT): branch = (A1 <  A2);
      OP_W'(CMP_NE): branch = (A1 != A2);
      default:       branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sched.sv
// ID-stage branch sequencer: waits for forwarded operands, captures them, resolves
// the branch one cycle later and emits a single-cycle PC redirect.
module branch_sched
  import branch_sched_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OP_W      = 4,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic          clk,
  input  logic          reset,
  branch_sched_if.slave bus
);

  localparam int SC_W = $clog2(MAX_STALL + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(MAX_STALL);
  localparam logic [SC_W-1:0] SC_ONE = SC_W'(1);

  state_t            state_r;
  logic [DATA_W-1:0] rs_r;
  logic [DATA_W-1:0] rt_r;
  logic [DATA_W-1:0] tgt_r;
  logic [DATA_W-1:0] last_tgt_r;
  logic [OP_W-1:0]   op_r;
  logic [SC_W-1:0]   stall_cnt_r;
  logic              hang_r;
  logic [CNT_W-1:0]  taken_r;
  logic [CNT_W-1:0]  nt_r;

  logic              cmp_s;
  logic              both_ready_s;
  logic              resolve_s;
  logic              redirect_s;
  logic              stall_s;
  logic [SC_W-1:0]   stall_inc_s;

  branch_sched_comparator #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_comparator (
    .A1     (rs_r),
    .A2     (rt_r),
    .OP     (op_r),
    .branch (cmp_s)
  );

  // Resolve/redirect qualifiers and the ID stall request
  always_comb begin
    both_ready_s = bus.rs_ready & bus.rt_ready;
    resolve_s    = (state_r == EVAL) & ~bus.flush;
    redirect_s   = resolve_s & cmp_s;
    stall_inc_s  = (stall_cnt_r >= SC_MAX) ? stall_cnt_r : stall_cnt_r + SC_ONE;
    stall_s      = 1'b0;
    if (!reset) begin
      stall_s = 1'b0;
    end else begin
      case (state_r)
        IDLE:    stall_s = bus.br_valid;
        WAIT:    stall_s = 1'b1;
        default: stall_s = 1'b0;
      endcase
    end
  end

  // Branch FSM with operand capture, watchdog and statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      rs_r        <= '0;
      rt_r        <= '0;
      tgt_r       <= '0;
      last_tgt_r  <= '0;
      op_r        <= '0;
      stall_cnt_r <= '0;
      hang_r      <= 1'b0;
      taken_r     <= '0;
      nt_r        <= '0;
    end else if (bus.flush) begin
      // A killed ID slot abandons the branch; the watchdog flag survives.
      state_r     <= IDLE;
      stall_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.br_valid && both_ready_s) begin
            rs_r    <= bus.rs_data;
            rt_r    <= bus.rt_data;
            op_r    <= bus.br_op;
            tgt_r   <= bus.br_target;
            state_r <= EVAL;
          end else if (bus.br_valid) begin
            stall_cnt_r <= SC_ONE;
            hang_r      <= hang_r | (SC_ONE >= SC_MAX);
            state_r     <= WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (both_ready_s) begin
            rs_r    <= bus.rs_data;
            rt_r    <= bus.rt_data;
            op_r    <= bus.br_op;
            tgt_r   <= bus.br_target;
            state_r <= EVAL;
          end else begin
            stall_cnt_r <= stall_inc_s;
            hang_r      <= hang_r | (stall_inc_s >= SC_MAX);
            state_r     <= WAIT;
          end
        end
        EVAL: begin
          if (cmp_s) begin
            last_tgt_r <= tgt_r;
            if (taken_r != {CNT_W{1'b1}}) begin
              taken_r <= taken_r + CNT_W'(1);
            end else begin
              taken_r <= taken_r;
            end
          end else begin
            if (nt_r != {CNT_W{1'b1}}) begin
              nt_r <= nt_r + CNT_W'(1);
            end else begin
              nt_r <= nt_r;
            end
          end
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.stall      = stall_s;
  assign bus.npc_sel    = redirect_s;
  assign bus.npc_target = redirect_s ? tgt_r : last_tgt_r;
  assign bus.br_done    = resolve_s;
  assign bus.br_taken   = redirect_s;
  assign bus.bad_op     = resolve_s & (op_r > OP_W'(CMP_NE));
  assign bus.hang_err   = hang_r;
  assign bus.taken_cnt  = taken_r;
  assign bus.nt_cnt     = nt_r;

endmodule

// File: doc/branch_sched.md
Name: branch_sched

Overview:
- ID-stage branch sequencer for the pipelined MIPS core.
- Captures the operands of a branch in ID once forwarding makes them valid, and drives the branch comparator with registered operands.
- Turns the comparator result into a one-cycle PC redirect, and stalls ID while the branch is unresolved.
- Also keeps saturating taken and not-taken statistics, plus a sticky watchdog for operands that never become ready.

Parameters:
DATA_W, 32, operand and target width
OP_W, 4, comparator opcode width
CNT_W, 16, width of each statistics counter
MAX_STALL, 8, operand-wait cycles before hang_err is set

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (0 = reset)
br_valid  in  1  ID holds a branch instruction
br_op  in  OP_W  compare op: 0 eq, 1 ge, 2 gt, 3 le, 4 lt, 5 ne (unsigned); others = never taken
rs_ready  in  1  rs value valid after forwarding
rt_ready  in  1  rt value valid after forwarding
rs_data  in  DATA_W  forwarded rs value
rt_data  in  DATA_W  forwarded rt value
br_target  in  DATA_W  computed branch target
flush  in  1  exception/eret kill of ID
stall  out  1  hold PC and IF/ID
npc_sel  out  1  one-cycle pulse: PC takes npc_target
npc_target  out  DATA_W  redirect address
br_done  out  1  one-cycle pulse: branch resolved
br_taken  out  1  outcome, valid only with br_done
bad_op  out  1  pulse with br_done when captured op > 5
hang_err  out  1  sticky watchdog flag
taken_cnt  out  CNT_W  saturating count of taken branches
nt_cnt  out  CNT_W  saturating count of not-taken branches

Behaviour:
- States: IDLE, WAIT, EVAL.
- Reset (asynchronous, reset=0): state=IDLE, all operand/op/target registers 0, stall_cnt 0. All outputs 0, including both counters and hang_err.
- IDLE, br_valid=1 and rs_ready=1 and rt_ready=1:
  - capture rs_data, rt_data, br_op, br_target; stall=1; go to EVAL.
- IDLE, br_valid=1 and either ready=0:
  - stall=1; stall_cnt=1; go to WAIT.
- IDLE, br_valid=0: stall=0; stay in IDLE.
- WAIT:
  - stall=1.
  - When both ready: capture operands, op and target; go to EVAL.
  - Otherwise stall_cnt increments, saturating; when stall_cnt reaches MAX_STALL, hang_err is set and stays set until reset. The FSM keeps waiting.
- EVAL:
  - The comparator sub-module evaluates the registered operands combinationally. stall=0, so the branch leaves ID at the end of this cycle.
  - br_done=1; br_taken = comparator result.
  - Taken: npc_sel=1, npc_target = captured target, taken_cnt increments.
  - Not taken: npc_sel=0, nt_cnt increments.
  - bad_op=1 if captured op > 5.
  - Always return to IDLE.
- Latency:
  - operands ready at entry: redirect in the cycle after the capture cycle, exactly 1 stall cycle;
  - each WAIT cycle adds 1.
- br_valid seen in EVAL refers to the same branch and is ignored.
- The delay-slot instruction is never flushed: the redirect applies to the fetch after the delay slot.
- flush=1 in any state:
  - next state IDLE; stall_cnt cleared;
  - no br_done or npc_sel in that cycle; counters unchanged.
  - flush has priority over a simultaneous capture or EVAL.
  - hang_err is not cleared by flush.
- Counters saturate at 2^CNT_W-1 and never wrap.
- npc_target is held at its last value when npc_sel=0.
- Reset asserted mid-WAIT or mid-EVAL aborts the branch with no pulses.

Decomposition:
- Shared package:
  - comparator op encodings CMP_EQ..CMP_NE (0..5);
  - state encoding constants IDLE/WAIT/EVAL;
  - DATA_W default.
- One sub-module: instantiate the existing `comparator` block (A1, A2, OP, branch) fed from the captured registers. No other hierarchy.

Test Plan:
- beq ready: br_valid=1, op=0, rs=rt=0x1234, target=0x3040, both ready -> stall=1 for 1 cycle; next cycle npc_sel=1, npc_target=0x3040, br_taken=1; taken_cnt=1.
- bgt not taken: op=2, rs=5, rt=7, both ready -> br_done=1, br_taken=0, npc_sel=0; nt_cnt=1.
- Forwarding wait: rt_ready low for 3 cycles, then high; op=5, rs=1, rt=2 -> stall high for 4 cycles, then redirect pulse; hang_err stays 0.
- Watchdog: rs_ready held low for 10 cycles with MAX_STALL=8 -> hang_err rises after the 8th wait cycle and stays 1 after ready rises; a flush does not clear it.
- Flush in EVAL: flush=1 in the resolve cycle of a taken beq -> no npc_sel, no br_done, counters unchanged, state IDLE next cycle.
- Bad op and saturation: op=7 with rs=rt -> br_taken=0, bad_op=1. With CNT_W=2, 5 taken branches -> taken_cnt=3. reset=0 mid-WAIT -> all outputs 0 immediately.
